// File: rtl/seg7_pkg.sv
// seg7_pkg: hex-to-segment table, decode function and width helpers for the paged 7-segment scanner
package seg7_pkg;

   localparam int SEG_W = 7;

   // {g,f,e,d,c,b,a}, 1 = lit
   localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [SEG_W-1:0] hex2seg(input logic [3:0] h);
      return HEX_SEG[h];
   endfunction

   // counter/index width that never collapses to zero bits
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int pages_of(input int value_w, input int digits);
      return (value_w + 4 * digits - 1) / (4 * digits);
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to 7-segment pattern
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0]       nib,
   output logic [SEG_W-1:0] seg
);

   assign seg = hex2seg(nib);

endmodule

// File: rtl/seg7_paged_scanner.sv
// seg7_paged_scanner: paged multiplexed 7-segment driver with tear-free handshaked updates; SEG7_LZB_EN enables leading-zero blanking
module seg7_paged_scanner
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int VALUE_W  = 32,
   parameter int SCAN_DIV = 12000,
   parameter int PAGE_DIV = 2**24
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic [VALUE_W-1:0]                              value,
   input  logic                                            load,
   output logic                                            ready,
   input  logic                                            enable,
   output logic [SEG_W-1:0]                                segment,
   output logic [DIGITS-1:0]                               dmask,
   output logic [width_of(pages_of(VALUE_W, DIGITS))-1:0]  page,
   output logic                                            colon
);

   localparam int PAGES  = pages_of(VALUE_W, DIGITS);
   localparam int PG_W   = width_of(PAGES);
   localparam int DG_W   = width_of(DIGITS);
   localparam int SC_W   = width_of(SCAN_DIV);
   localparam int PC_W   = width_of(PAGE_DIV);
   localparam int WIDE_W = PAGES * 4 * DIGITS;

   logic [SC_W-1:0]    scan_cnt, scan_nx;
   logic [DG_W-1:0]    digit, digit_nx;
   logic [PC_W-1:0]    page_cnt, page_cnt_nx;
   logic [PG_W-1:0]    page_req, page_req_nx, page_nx;
   logic [VALUE_W-1:0] pending, pending_nx, shown, shown_nx;
   logic               ready_nx, scan_wrap, page_wrap, boundary, take, blank;
   logic [WIDE_W-1:0]  wide;
   logic [3:0]         nibs [PAGES][DIGITS];
   logic [3:0]         nib;
   logic [SEG_W-1:0]   seg_raw;

   // next-state for scan, paging and the pending/shown handshake
   always_comb begin
      scan_wrap   = scan_cnt == SC_W'(SCAN_DIV - 1);
      boundary    = scan_wrap && digit == DG_W'(DIGITS - 1);
      page_wrap   = page_cnt == PC_W'(PAGE_DIV - 1);
      take        = load && ready;
      scan_nx     = scan_wrap ? '0 : scan_cnt + 1'b1;
      digit_nx    = !scan_wrap ? digit : boundary ? '0 : digit + 1'b1;
      page_cnt_nx = page_wrap ? '0 : page_cnt + 1'b1;
      page_req_nx = !page_wrap ? page_req : page_req == PG_W'(PAGES - 1) ? '0 : page_req + 1'b1;
      page_nx     = boundary ? page_req : page;
      pending_nx  = take ? value : pending;
      shown_nx    = boundary ? pending_nx : shown;
      ready_nx    = boundary || (ready && !take);
   end

   // zero-extended word split into per-page, per-digit nibbles
   assign wide = WIDE_W'(shown_nx);
   for (genvar p = 0; p < PAGES; p++) begin : g_p
      for (genvar d = 0; d < DIGITS; d++) begin : g_d
         assign nibs[p][d] = wide[(p * DIGITS + d) * 4 +: 4];
      end
   end

   // select the nibble for the digit about to be shown and decide blanking
   always_comb begin
      nib   = nibs[page_nx][digit_nx];
      blank = 1'b0;
`ifdef SEG7_LZB_EN
      blank = digit_nx != '0;
      for (int k = 0; k < DIGITS; k++)
         if (k >= int'(digit_nx) && nibs[page_nx][k] != 4'd0) blank = 1'b0;
`endif
   end

   seg7_hex_decode u_dec (
      .nib (nib),
      .seg (seg_raw)
   );

   // state and outputs register from the same next-state view so they stay aligned
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         digit    <= '0;
         page_cnt <= '0;
         page_req <= '0;
         page     <= '0;
         pending  <= '0;
         shown    <= '0;
         ready    <= 1'b1;
         segment  <= '0;
         dmask    <= '0;
         colon    <= 1'b0;
      end else begin
         scan_cnt <= scan_nx;
         digit    <= digit_nx;
         page_cnt <= page_cnt_nx;
         page_req <= page_req_nx;
         page     <= page_nx;
         pending  <= pending_nx;
         shown    <= shown_nx;
         ready    <= ready_nx;
         segment  <= (enable && !blank) ? seg_raw : '0;
         dmask    <= enable ? DIGITS'(1) << digit_nx : '0;
         colon    <= page_nx != '0;
      end
   end

endmodule

// File: tb/tb_seg7_paged_scanner.sv
// tb_seg7_paged_scanner: directed scoreboard bench for seg7_paged_scanner (DIGITS=4, VALUE_W=32, SCAN_DIV=4, PAGE_DIV=64; honours SEG7_LZB_EN)
module tb_seg7_paged_scanner;

   logic        clk;
   logic        rst_n;
   logic [31:0] value;
   logic        load;
   logic        ready;
   logic        enable;
   logic [6:0]  segment;
   logic [3:0]  dmask;
   logic [0:0]  page;
   logic        colon;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] dm;
      logic       pg;
   } exp_t;

   exp_t sb [$];

`ifdef SEG7_LZB_EN
   localparam logic [6:0] Z = 7'h00;
`else
   localparam logic [6:0] Z = 7'h3F;
`endif

   seg7_paged_scanner #(
      .DIGITS   (4),
      .VALUE_W  (32),
      .SCAN_DIV (4),
      .PAGE_DIV (64)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .value   (value),
      .load    (load),
      .ready   (ready),
      .enable  (enable),
      .segment (segment),
      .dmask   (dmask),
      .page    (page),
      .colon   (colon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [6:0] s0, s1, s2, s3, input logic pg);
      logic [6:0] s [4];
      s = '{s0, s1, s2, s3};
      for (int d = 0; d < 4; d++) sb.push_back('{seg: s[d], dm: 4'(1 << d), pg: pg});
   endtask

   task automatic check_frame(input int start);
      exp_t e;
      for (int d = 0; d < 4; d++) begin
         goto(start + 4 * d + 1);
         e = sb.pop_front();
         chk($sformatf("seg[%0d]", d), segment, e.seg);
         chk($sformatf("dmask[%0d]", d), dmask, e.dm);
         chk($sformatf("page[%0d]", d), page, e.pg);
         chk($sformatf("colon[%0d]", d), colon, e.pg);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      load   = 1'b0;
      enable = 1'b1;
      value  = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      cyc   = 0;
      chk("rst_seg", segment, 0);
      chk("rst_dmask", dmask, 0);
      chk("rst_ready", ready, 1);
      chk("rst_page", page, 0);
      chk("rst_colon", colon, 0);
      goto(2);
      value = 32'hDEAD_BEEF;
      load  = 1'b1;
      tick();
      load = 1'b0;
      chk("ready_drop0", ready, 0);
      goto(7);
      chk("dmask_prerst", dmask, 4'b0010);
      chk("ready_prerst", ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_seg", segment, 0);
      chk("arst_dmask", dmask, 0);
      chk("arst_ready", ready, 1);
      chk("arst_page", page, 0);
      chk("arst_colon", colon, 0);
      tick();
      rst_n = 1'b1;
      cyc   = 0;
      goto(3);
      value = 32'h1234_ABCD;
      load  = 1'b1;
      tick();
      load  = 1'b0;
      value = '0;
      chk("ready_drop", ready, 0);
      push_frame(7'h5E, 7'h39, 7'h7C, 7'h77, 1'b0);
      goto(15);
      chk("ready_at_bnd", ready, 0);
      tick();
      chk("ready_rise", ready, 1);
      check_frame(16);
      goto(79);
      chk("page_hold", page, 0);
      chk("colon_hold", colon, 0);
      tick();
      chk("page_flip", page, 1);
      chk("colon_flip", colon, 1);
      push_frame(7'h66, 7'h4F, 7'h5B, 7'h06, 1'b1);
      check_frame(80);
      goto(97);
      value = 32'h1234_ABCD;
      load  = 1'b1;
      tick();
      value = 32'hFFFF_FFFF;
      chk("ready_drop2", ready, 0);
      goto(105);
      chk("ready_ignore", ready, 0);
      goto(112);
      load = 1'b0;
      chk("ready_rise2", ready, 1);
      push_frame(7'h66, 7'h4F, 7'h5B, 7'h06, 1'b1);
      check_frame(112);
      goto(143);
      chk("page_hold1", page, 1);
      tick();
      chk("page_back", page, 0);
      chk("colon_back", colon, 0);
      push_frame(7'h5E, 7'h39, 7'h7C, 7'h77, 1'b0);
      check_frame(144);
      goto(159);
      chk("ready_pre_byp", ready, 1);
      value = 32'h0000_0005;
      load  = 1'b1;
      tick();
      load = 1'b0;
      chk("ready_bypass", ready, 1);
      push_frame(7'h6D, Z, Z, Z, 1'b0);
      check_frame(160);
      goto(176);
      enable = 1'b0;
      repeat (10) begin
         tick();
         chk("dis_dmask", dmask, 0);
         chk("dis_seg", segment, 0);
      end
      enable = 1'b1;
      tick();
      chk("reen_dmask", dmask, 4'b0100);
      chk("reen_seg", segment, Z);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
